// File: rtl/gsensor_sequencer.sv
// gsensor_sequencer: configures an ADXL345-class G-sensor through a byte SPI master, then polls X/Y on a fixed tick
// Ports: MAX10_CLK1_50 clock, reset async active-high; spi_start/rw/addr/wdata request and spi_busy/done/rdata
//        handshake to the SPI master; data_x/data_y/data_valid published samples; init_done, fault (sticky
//        timeout) and overrun (dropped tick) status.
module gsensor_sequencer #(
  parameter int SAMPLE_DIV = 250000,
  parameter int TIMEOUT = 4096,
  parameter logic [7:0] CFG_FORMAT = 8'h0B,
  parameter logic [7:0] CFG_RATE = 8'h0A,
  parameter logic [7:0] CFG_POWER = 8'h08
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  output logic        spi_start,
  output logic        spi_rw,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic        data_valid,
  output logic        init_done,
  output logic        fault,
  output logic        overrun
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int OW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {INIT, WAIT, READ, PUBLISH, RECOVER} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] tmo_q, tmo_d;
  logic [3:0] rec_q, rec_d;
  logic armed_q, out_q, out_d, pend_q, pend_d;
  logic rw_q, rw_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, x0_q, x0_d, x1_q, x1_d, y0_q, y0_d;
  logic [15:0] data_x_q, data_x_d, data_y_q, data_y_d;
  logic valid_q, valid_d, init_q, init_d, fault_q, fault_d, ovr_q, ovr_d;
  logic wrap, consume, accept;
  // Issue is combinational so it sees spi_busy in the very cycle it fires; armed_q keeps it low
  // until the request registers hold the first INIT write after reset.
  assign spi_start = armed_q && !out_q && !spi_busy && (state_q == INIT || state_q == READ);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rec_d = rec_q;
    out_d = out_q || spi_start;
    x0_d = x0_q;
    x1_d = x1_q;
    y0_d = y0_q;
    data_x_d = data_x_q;
    data_y_d = data_y_q;
    valid_d = 1'b0;
    init_d = init_q;
    fault_d = fault_q;
    wrap = tick_q == TW'(SAMPLE_DIV - 1);
    consume = state_q == WAIT && pend_q;
    tick_d = wrap ? '0 : tick_q + 1'b1;
    pend_d = wrap || (pend_q && !consume);
    ovr_d = wrap && pend_q && !consume;
    accept = out_q && spi_done;
    // The start cycle counts as cycle 0, so the fault lands exactly TIMEOUT cycles after spi_start.
    tmo_d = spi_start ? OW'(1) : out_q ? tmo_q + 1'b1 : tmo_q;
    case (state_q)
      INIT: if (accept) begin
        out_d = 1'b0;
        idx_d = idx_q == 2'd2 ? 2'd0 : idx_q + 1'b1;
        if (idx_q == 2'd2) begin
          init_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: if (pend_q) state_d = READ;
      READ: if (accept) begin
        out_d = 1'b0;
        idx_d = idx_q + 1'b1;
        x0_d = idx_q == 2'd0 ? spi_rdata : x0_q;
        x1_d = idx_q == 2'd1 ? spi_rdata : x1_q;
        y0_d = idx_q == 2'd2 ? spi_rdata : y0_q;
        // Publish straight from the last byte so data_valid trails the 4th spi_done by one cycle.
        if (idx_q == 2'd3) begin
          data_x_d = {x1_q, x0_q};
          data_y_d = {spi_rdata, y0_q};
          valid_d = 1'b1;
          state_d = PUBLISH;
        end
      end
      PUBLISH: state_d = WAIT;
      RECOVER: begin
        rec_d = rec_q + 1'b1;
        if (rec_q == 4'd15) begin
          state_d = INIT;
          idx_d = 2'd0;
        end
      end
      default: state_d = INIT;
    endcase
    if (out_q && !spi_done && tmo_q == OW'(TIMEOUT - 1)) begin
      fault_d = 1'b1;
      init_d = 1'b0;
      out_d = 1'b0;
      idx_d = 2'd0;
      rec_d = 4'd0;
      state_d = RECOVER;
    end
    // Request fields are staged one cycle ahead from the next state so they are stable when spi_start fires.
    rw_d = state_d == READ;
    addr_d = state_d == READ ? 6'h32 + {4'b0, idx_d} : idx_d == 2'd0 ? 6'h31 : idx_d == 2'd1 ? 6'h2C : 6'h2D;
    wdata_d = state_d == READ ? 8'h00 : idx_d == 2'd0 ? CFG_FORMAT : idx_d == 2'd1 ? CFG_RATE : CFG_POWER;
  end
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      idx_q <= '0;
      tick_q <= '0;
      tmo_q <= '0;
      rec_q <= '0;
      armed_q <= 1'b0;
      out_q <= 1'b0;
      pend_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      data_x_q <= '0;
      data_y_q <= '0;
      valid_q <= 1'b0;
      init_q <= 1'b0;
      fault_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tick_q <= tick_d;
      tmo_q <= tmo_d;
      rec_q <= rec_d;
      armed_q <= 1'b1;
      out_q <= out_d;
      pend_q <= pend_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      data_x_q <= data_x_d;
      data_y_q <= data_y_d;
      valid_q <= valid_d;
      init_q <= init_d;
      fault_q <= fault_d;
      ovr_q <= ovr_d;
    end
  end
  assign spi_rw = rw_q;
  assign spi_addr = addr_q;
  assign spi_wdata = wdata_q;
  assign data_x = data_x_q;
  assign data_y = data_y_q;
  assign data_valid = valid_q;
  assign init_done = init_q;
  assign fault = fault_q;
  assign overrun = ovr_q;
endmodule
